// File: rtl/pcache_pkg.sv
// Shared types and helpers for the pcache direct-mapped cache.
// Holds the controller state encoding and the load-data formatting.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    WRITE
  } state_e;

  // Little-endian byte positions within a 32-bit word.
  localparam int BYTE0 = 0;
  localparam int BYTE1 = 1;
  localparam int BYTE2 = 2;
  localparam int BYTE3 = 3;

  function automatic int clog2(input int value);
    int r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  // Word loads pass through; byte loads pick a lane and sign-extend it.
  function automatic logic [31:0] load_format(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic        is_word);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[8*BYTE0 +: 8];
      2'd1:    b = word[8*BYTE1 +: 8];
      2'd2:    b = word[8*BYTE2 +: 8];
      default: b = word[8*BYTE3 +: 8];
    endcase
    return is_word ? word : {{24{b[7]}}, b};
  endfunction

endpackage

// File: rtl/pcache_if.sv
// CPU-side and memory-side handshake signals of pcache.
// slave = the cache itself; master = the pipeline/memory pair driving it.
interface pcache_if #(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 8
);
  logic                    cpu_req;
  logic                    cpu_we;
  logic                    cpu_word;
  logic [ADDR_W-1:0]       cpu_addr;
  logic [31:0]             cpu_wdata;
  logic [31:0]             cpu_rdata;
  logic                    cpu_ready;
  logic                    mem_req;
  logic                    mem_we;
  logic                    mem_word;
  logic [ADDR_W-1:0]       mem_addr;
  logic [31:0]             mem_wdata;
  logic [8*LINE_BYTES-1:0] mem_rdata;
  logic                    mem_ack;

  modport slave (
    input  cpu_req, cpu_we, cpu_word, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    output cpu_rdata, cpu_ready, mem_req, mem_we, mem_word, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_word, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
    input  cpu_rdata, cpu_ready, mem_req, mem_we, mem_word, mem_addr, mem_wdata
  );
endinterface

// File: rtl/pcache_tags.sv
// Valid + tag array for pcache: cleared on reset, filled one line at a time,
// combinational lookup against the current request.
module pcache_tags #(
  parameter int LINES = 32,
  parameter int IDX_W = 5,
  parameter int TAG_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_fill,
  input  logic [IDX_W-1:0] i_fill_idx,
  input  logic [TAG_W-1:0] i_fill_tag,
  output logic             o_hit
);

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag [LINES];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_valid <= '0;
    else if (i_fill) r_valid[i_fill_idx] <= 1'b1;
  end

  // NOTE: storage arrays carry no reset; the valid bits alone make stale contents harmless.
  always_ff @(posedge clk) begin
    if (i_fill) r_tag[i_fill_idx] <= i_fill_tag;
  end

  assign o_hit = r_valid[i_idx] & (r_tag[i_idx] == i_tag);

endmodule

// File: rtl/pcache.sv
// Direct-mapped, write-through, no-write-allocate cache with refill controller
// and saturating read-miss counter.
module pcache
  import cache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int LINES      = 32,
  parameter int LINE_BYTES = 8
) (
  input  logic        clk,
  input  logic        rst,
  pcache_if.slave     bus,
  output logic [31:0] miss_cnt
);

  localparam int OFF_W  = clog2(LINE_BYTES);
  localparam int IDX_W  = clog2(LINES);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int LINE_W = 8 * LINE_BYTES;

  logic [TAG_W-1:0]      w_tag;
  logic [IDX_W-1:0]      w_idx;
  logic [OFF_W-1:0]      w_off;
  logic [OFF_W-1:0]      w_word_off;
  logic                  w_hit_raw, w_hit;
  logic                  w_ready, w_mem_req, w_mem_we;
  logic                  w_fill, w_store, w_miss;
  logic [LINE_BYTES-1:0] w_be;
  logic [LINE_W-1:0]     w_wline, w_line;
  logic [31:0]           w_word;

  state_e           r_state, w_next;
  logic [TAG_W-1:0] r_fill_tag;
  logic [IDX_W-1:0] r_fill_idx;
  logic [31:0]      r_miss_cnt;
  logic [LINE_W-1:0] r_data [LINES];

  assign {w_tag, w_idx, w_off} = bus.cpu_addr;
  assign w_word_off = w_off & ~OFF_W'(3);

  pcache_tags #(.LINES(LINES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_tags (
    .clk        (clk),
    .rst        (rst),
    .i_idx      (w_idx),
    .i_tag      (w_tag),
    .i_fill     (w_fill),
    .i_fill_idx (r_fill_idx),
    .i_fill_tag (r_fill_tag),
    .o_hit      (w_hit_raw)
  );

  assign w_hit = bus.cpu_req & w_hit_raw;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    w_next    = r_state;
    w_ready   = 1'b0;
    w_mem_req = 1'b0;
    w_mem_we  = 1'b0;
    w_fill    = 1'b0;
    w_store   = 1'b0;
    w_miss    = 1'b0;
    if (!rst) begin
      unique case (r_state)
        IDLE: begin
          if (bus.cpu_req) begin
            if (bus.cpu_we) w_next = WRITE;
            else if (w_hit) w_ready = 1'b1;
            else begin
              w_next = REFILL;
              w_miss = 1'b1;
            end
          end
        end
        REFILL: begin
          w_mem_req = 1'b1;
          if (bus.mem_ack) begin
            w_fill = 1'b1;
            w_next = IDLE;
          end
        end
        WRITE: begin
          w_mem_req = 1'b1;
          w_mem_we  = 1'b1;
          if (bus.mem_ack) begin
            w_ready = 1'b1;
            w_store = w_hit;
            w_next  = IDLE;
          end
        end
        default: w_next = IDLE;
      endcase
    end
  end

  // The refill target is captured on the miss so a dropped request cannot move it.
  always_ff @(posedge clk) begin
    if (w_miss) begin
      r_fill_tag <= w_tag;
      r_fill_idx <= w_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_miss_cnt <= '0;
    else if (w_miss && r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + 32'd1;
  end

  always_comb begin
    w_wline = bus.cpu_word ? {(LINE_BYTES/4){bus.cpu_wdata}} : {LINE_BYTES{bus.cpu_wdata[7:0]}};
    for (int b = 0; b < LINE_BYTES; b++) begin
      w_be[b] = bus.cpu_word ? ((OFF_W'(b) >> 2) == (w_off >> 2)) : (OFF_W'(b) == w_off);
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill) r_data[r_fill_idx] <= bus.mem_rdata;
    else if (w_store) begin
      for (int b = 0; b < LINE_BYTES; b++) begin
        if (w_be[b]) r_data[w_idx][8*b +: 8] <= w_wline[8*b +: 8];
      end
    end
  end

  assign w_line = r_data[w_idx];
  assign w_word = w_line[{w_word_off, 3'b000} +: 32];

  assign bus.cpu_rdata = load_format(w_word, w_off[1:0], bus.cpu_word);
  assign bus.cpu_ready = w_ready;
  assign bus.mem_req   = w_mem_req;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_word  = bus.cpu_word;
  assign bus.mem_wdata = bus.cpu_wdata;
  assign bus.mem_addr  = (r_state == REFILL) ? {r_fill_tag, r_fill_idx, {OFF_W{1'b0}}}
                                             : bus.cpu_addr;
  assign miss_cnt      = r_miss_cnt;

endmodule

// File: tb/tb_pcache.sv
// Self-checking bench for pcache: vector table through a CPU/memory driver
// with a load-data scoreboard, plus a reset-during-refill sequence.
module tb_pcache;

  logic        clk;
  logic        rst;
  logic [31:0] miss_cnt;

  pcache_if #(.ADDR_W(32), .LINE_BYTES(8)) bus ();

  pcache #(.ADDR_W(32), .LINES(32), .LINE_BYTES(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .miss_cnt (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        word;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_refill;
    logic [31:0] exp_cnt;
  } vec_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  mem_bytes [int unsigned];
  vec_t        vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [7:0] mem_rd(input int unsigned a);
    if (mem_bytes.exists(a)) return mem_bytes[a];
    return 8'(a) + 8'h30;
  endfunction

  function automatic logic [63:0] mem_line(input int unsigned a);
    logic [63:0] l;
    for (int b = 0; b < 8; b++) l[8*b +: 8] = mem_rd((a & ~32'd7) + b);
    return l;
  endfunction

  task automatic mem_write(input logic [31:0] a, input logic [31:0] d, input logic word);
    if (word) begin
      for (int b = 0; b < 4; b++) mem_bytes[(a & ~32'd3) + b] = d[8*b +: 8];
    end else begin
      mem_bytes[a] = d[7:0];
    end
  endtask

  // Drives one access, acts as memory, and checks latency/addresses/data/counter.
  task automatic run_vec(input vec_t v, input string name);
    bit done = 0, acked_prev = 0, saw_req = 0, refilled = 0;
    int lat = -1;
    logic [31:0] exp_d;
    @(negedge clk);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = v.we;
    bus.cpu_word  = v.word;
    bus.cpu_addr  = v.addr;
    bus.cpu_wdata = v.wdata;
    if (!v.we) exp_q.push_back(v.exp_rdata);
    for (int cyc = 0; cyc < 20 && !done; cyc++) begin
      if (cyc != 0) @(negedge clk);
      bus.mem_ack = 1'b0;
      #1;
      if (acked_prev) begin
        check({name, " mem_req_drop"}, bus.mem_req, 0);
        acked_prev = 0;
      end else if (bus.mem_req) begin
        if (!saw_req) begin
          check({name, " mem_we"}, bus.mem_we, v.we);
          check({name, " mem_addr"}, bus.mem_addr, v.we ? v.addr : (v.addr & ~32'd7));
          saw_req = 1;
        end
        if (bus.mem_we) mem_write(bus.mem_addr, bus.mem_wdata, bus.mem_word);
        else begin
          bus.mem_rdata = mem_line(bus.mem_addr);
          refilled = 1;
        end
        bus.mem_ack = 1'b1;
        acked_prev  = 1;
        #1;
      end
      if (bus.cpu_ready) begin
        done = 1;
        lat  = cyc;
        if (!v.we) begin
          exp_d = exp_q.pop_front();
          check({name, " rdata"}, bus.cpu_rdata, exp_d);
        end
      end
    end
    check({name, " done"}, done, 1);
    if (!done) exp_q.delete();
    check({name, " latency"}, lat, v.we ? 1 : (v.exp_refill ? 2 : 0));
    check({name, " refill"}, refilled, v.exp_refill);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    bus.mem_ack = 1'b0;
    #1;
    check({name, " idle_req"}, bus.mem_req, 0);
    check({name, " miss_cnt"}, miss_cnt, v.exp_cnt);
  endtask

  initial begin
    vec_t v;
    //           we word addr       wdata         rdata         refill cnt
    vecs[0]  = '{0, 1, 32'h40,   32'h0,        32'h44332211, 1, 1};
    vecs[1]  = '{0, 0, 32'h47,   32'h0,        32'hFFFFFF88, 0, 1};
    vecs[2]  = '{1, 1, 32'h44,   32'hDEADBEEF, 32'h0,        0, 1};
    vecs[3]  = '{0, 1, 32'h44,   32'h0,        32'hDEADBEEF, 0, 1};
    vecs[4]  = '{0, 1, 32'h46,   32'h0,        32'hDEADBEEF, 0, 1};
    vecs[5]  = '{1, 1, 32'h1000, 32'h12345678, 32'h0,        0, 1};
    vecs[6]  = '{0, 1, 32'h1000, 32'h0,        32'h12345678, 1, 2};
    vecs[7]  = '{0, 1, 32'h140,  32'h0,        32'h73727170, 1, 3};
    vecs[8]  = '{0, 1, 32'h40,   32'h0,        32'h44332211, 1, 4};
    vecs[9]  = '{0, 1, 32'h140,  32'h0,        32'h73727170, 1, 5};
    vecs[10] = '{0, 1, 32'h40,   32'h0,        32'h44332211, 1, 6};
    vecs[11] = '{1, 0, 32'h42,   32'h000000AB, 32'h0,        0, 6};
    vecs[12] = '{0, 1, 32'h40,   32'h0,        32'h44AB2211, 0, 6};
    vecs[13] = '{0, 0, 32'h42,   32'h0,        32'hFFFFFFAB, 0, 6};
    vecs[14] = '{0, 0, 32'h41,   32'h0,        32'h00000022, 0, 6};
    vecs[15] = '{0, 1, 32'h47,   32'h0,        32'hDEADBEEF, 0, 6};

    for (int b = 0; b < 8; b++) mem_bytes[32'h40 + b] = 8'(8'h11 * (b + 1));

    rst           = 1'b1;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_word  = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.mem_rdata = '0;
    bus.mem_ack   = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset mem_req", bus.mem_req, 0);
    check("reset cpu_ready", bus.cpu_ready, 0);
    check("reset miss_cnt", miss_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_reset mem_req", bus.mem_req, 0);

    for (int i = 0; i < 16; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset lands while a refill of 0x140 is outstanding; a stray ack follows.
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_word = 1'b1;
    bus.cpu_addr = 32'h140;
    @(negedge clk);
    #1;
    check("rst_seq pre_req", bus.mem_req, 1);
    check("rst_seq pre_addr", bus.mem_addr, 32'h140);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rst_seq mem_req", bus.mem_req, 0);
    check("rst_seq cpu_ready", bus.cpu_ready, 0);
    check("rst_seq miss_cnt", miss_cnt, 0);
    rst           = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.mem_rdata = {8{8'hFF}};
    bus.mem_ack   = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    check("rst_seq stray_ack mem_req", bus.mem_req, 0);
    check("rst_seq stray_ack miss_cnt", miss_cnt, 0);
    v = '{0, 1, 32'h40, 32'h0, 32'h44AB2211, 1, 1};
    run_vec(v, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pcache.md
Name: pcache

Overview:
- Parametrised direct-mapped cache with its own miss/refill controller. Next generation of the fixed 32-line, 8-byte-line tag and data arrays.
- Adds valid bits cleared on reset, a CPU ready/stall handshake, a memory request/ack handshake, write-through with no write-allocate, and a miss counter.
- Sits between the pipeline memory stage (or fetch stage, with writes tied off) and main memory.

Parameters:
- ADDR_W, 32, CPU/memory byte-address width.
- LINES, 32, number of lines; power of two, ≥2.
- LINE_BYTES, 8, bytes per line; power of two, ≥4.
- Derived, not overridable:
  - OFF_W = log2(LINE_BYTES)
  - IDX_W = log2(LINES)
  - TAG_W = ADDR_W-IDX_W-OFF_W

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  access request; held stable with cpu_we, cpu_word, cpu_addr and cpu_wdata until cpu_ready.
- cpu_we  in  1  1=store, 0=load.
- cpu_word  in  1  1=32-bit word access, 0=byte access.
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  32  store data; for byte stores only [7:0] is used.
- cpu_rdata  out  32  load data; valid when cpu_ready & ~cpu_we.
- cpu_ready  out  1  access completes this cycle.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  1=write-through, 0=line refill.
- mem_word  out  1  write size, copy of cpu_word.
- mem_addr  out  ADDR_W  refill: line-aligned address; write: cpu_addr.
- mem_wdata  out  32  copy of cpu_wdata.
- mem_rdata  in  8*LINE_BYTES  refill line, little-endian (byte 0 in [7:0]).
- mem_ack  in  1  one-cycle completion pulse.
- miss_cnt  out  32  saturating count of read misses.

Behaviour:
- Address split: tag=addr[ADDR_W-1:OFF_W+IDX_W], idx=addr[OFF_W+IDX_W-1:OFF_W], off=addr[OFF_W-1:0].
- Word accesses ignore off[1:0] (forced word-aligned). Never straddle a line.
- hit = cpu_req & valid[idx] & (tag_arr[idx]==tag); combinational.
- Reset values: all valid=0, state=IDLE, mem_req=0, miss_cnt=0, cpu_ready=0.
  - Data and tag arrays are not reset.
  - rst wins over every simultaneous event.
- FSM states: IDLE, REFILL, WRITE.
- IDLE:
  - Read hit: cpu_ready=1 in the same cycle, cpu_rdata from the array (zero-latency).
  - Read miss: cpu_ready=0; next state REFILL; miss_cnt += 1 (saturating at 0xFFFFFFFF).
  - Store (hit or miss): next state WRITE; cpu_ready=0.
  - mem_ack while IDLE is ignored.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr={tag,idx,OFF_W'b0}, stable until ack.
  - On mem_ack: write the whole line, tag_arr[idx]=tag, valid[idx]=1; go to IDLE; cpu_ready stays 0.
  - The held request hits the following cycle, so read-miss latency = ack cycle + 1.
  - If cpu_req drops mid-refill (protocol violation), the refill still completes and fills the line.
- WRITE:
  - mem_req=1, mem_we=1, mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_word=cpu_word.
  - On mem_ack: cpu_ready=1. If the line hit when sampled in the ack cycle, update the 4 or 1 bytes at off. Go to IDLE.
  - Write miss: no allocation; valid unchanged.
- Load data:
  - Word: bytes off..off+3, little-endian.
  - Byte: byte off, sign-extended to 32 bits.
- mem_req deasserts the cycle after mem_ack. Back-to-back accesses are allowed; a new request is evaluated in IDLE.
- Reset mid-REFILL/WRITE: mem_req=0 the next cycle and no array update. A late mem_ack after reset is ignored.

Decomposition:
- Package cache_pkg:
  - FSM state enum (IDLE/REFILL/WRITE).
  - clog2 function.
  - Byte-lane select / sign-extend function.
  - Little-endian byte-index constants.
- One sub-module, pcache_tags: parametrised valid+tag array with synchronous clear on rst, fill port (idx, tag) and combinational hit output.
- The data array and FSM stay in pcache.

Test Plan (LINES=32, LINE_BYTES=8):
- Reset, load word 0x40 → mem_req=1, mem_we=0, mem_addr=0x40. Ack with mem_rdata=0x8877665544332211 → next cycle cpu_ready=1, cpu_rdata=0x44332211, miss_cnt=1.
- Then load byte 0x47 → same-cycle cpu_ready=1, cpu_rdata=0xFFFFFF88, mem_req stays 0, miss_cnt=1.
- Store word 0xDEADBEEF at 0x44 (hit) → mem_req=1, mem_we=1, mem_addr=0x44, cpu_ready on ack. Then load word 0x44 → 0xDEADBEEF, no mem_req.
- Store word 0x12345678 at 0x1000 (miss) → memory write only. Then load 0x1000 → REFILL, miss_cnt increments.
- Alternate loads 0x40 and 0x140 (same idx=8, different tags), 4 times → every access refills, miss_cnt increases by 4.
- Assert rst during REFILL before ack → mem_req=0 the next cycle; a later stray mem_ack is ignored. Load 0x40 misses again with miss_cnt=1.
